// File: rtl/router_route_lock_if.sv
`default_nettype none
// ============================================================================
// Module : router_route_lock_if
// Brief  : Flit-in / flit-plus-route-out handshake bundle of the route-lock stage.
// Rev    : 1.0  initial release
// ============================================================================
interface router_route_lock_if #(
    parameter int FLIT_W = 32,
    parameter int CNT_W  = 16
);
    logic              in_valid_i;
    logic              in_ready_o;
    logic [FLIT_W-1:0] in_flit_i;
    logic              in_head_i;
    logic              in_tail_i;
    logic              out_valid_o;
    logic              out_ready_i;
    logic [FLIT_W-1:0] out_flit_o;
    logic              out_head_o;
    logic              out_tail_o;
    logic [1:0]        route_o;
    logic              dir_x_o;
    logic              dir_y_o;
    logic [CNT_W-1:0]  pkt_cnt_o;
    logic              err_o;

    modport slave (
        input  in_valid_i, in_flit_i, in_head_i, in_tail_i, out_ready_i,
        output in_ready_o, out_valid_o, out_flit_o, out_head_o, out_tail_o,
               route_o, dir_x_o, dir_y_o, pkt_cnt_o, err_o
    );

    modport master (
        output in_valid_i, in_flit_i, in_head_i, in_tail_i, out_ready_i,
        input  in_ready_o, out_valid_o, out_flit_o, out_head_o, out_tail_o,
               route_o, dir_x_o, dir_y_o, pkt_cnt_o, err_o
    );
endinterface
`default_nettype wire

// File: rtl/router_route_lock.sv
`default_nettype none
// ============================================================================
// Module : router_route_lock
// Brief  : Wormhole route compute/lock for one input port, one registered
//          valid/ready output stage. Optional ROUTE_ERRCHK_EN adds a sticky
//          range/protocol error flag.
// Rev    : 1.0  initial release
// ============================================================================
module router_route_lock #(
    parameter int MAXX   = 4,
    parameter int MAXY   = 4,
    parameter int SELFX  = 0,
    parameter int SELFY  = 0,
    parameter int FLIT_W = 32,
    parameter int CNT_W  = 16
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    router_route_lock_if.slave bus
);
    localparam int XW = (MAXX > 1) ? $clog2(MAXX) : 1;
    localparam int YW = (MAXY > 1) ? $clog2(MAXY) : 1;
    localparam logic [XW-1:0] c_selfx = XW'(SELFX);
    localparam logic [YW-1:0] c_selfy = YW'(SELFY);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_BODY = 1'b1
    } state_t;

    state_t            r_state;
    logic [1:0]        r_lock_route;
    logic              r_lock_dx;
    logic              r_lock_dy;
    logic              r_out_valid;
    logic [FLIT_W-1:0] r_out_flit;
    logic              r_out_head;
    logic              r_out_tail;
    logic [1:0]        r_out_route;
    logic              r_out_dx;
    logic              r_out_dy;
    logic [CNT_W-1:0]  r_pkt_cnt;

    logic              w_in_ready;
    logic              w_accept;
    logic              w_consume;
    logic [XW-1:0]     w_dst_x;
    logic [YW-1:0]     w_dst_y;
    logic              w_range_bad;
    logic [1:0]        w_head_route;
    logic              w_head_dx;
    logic              w_head_dy;

    assign w_in_ready = !r_out_valid || bus.out_ready_i;
    assign w_accept   = bus.in_valid_i && w_in_ready;
    assign w_consume  = r_out_valid && bus.out_ready_i;
    assign w_dst_x    = bus.in_flit_i[XW-1:0];
    assign w_dst_y    = bus.in_flit_i[XW+YW-1:XW];

`ifdef ROUTE_ERRCHK_EN
    localparam logic [XW:0] c_maxx = (XW+1)'(MAXX);
    localparam logic [YW:0] c_maxy = (YW+1)'(MAXY);

    logic w_proto_bad;
    logic r_err;

    assign w_range_bad = ({1'b0, w_dst_x} >= c_maxx) || ({1'b0, w_dst_y} >= c_maxy);
    // A head is only legal with no packet open; anything else only with one open.
    assign w_proto_bad = (r_state == ST_IDLE) ? !bus.in_head_i : bus.in_head_i;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_err <= 1'b0;
        end else if (w_accept && (w_proto_bad || (bus.in_head_i && w_range_bad))) begin
            r_err <= 1'b1;
        end
    end

    assign bus.err_o = r_err;
`else
    assign w_range_bad = 1'b0;
    assign bus.err_o   = 1'b0;
`endif

    // Route code is {x differs, y differs}; out-of-range heads eject to self.
    always_comb begin
        w_head_route = {w_dst_x != c_selfx, w_dst_y != c_selfy};
        w_head_dx    = w_dst_x > c_selfx;
        w_head_dy    = w_dst_y > c_selfy;
        if (w_range_bad) begin
            w_head_route = 2'b00;
            w_head_dx    = 1'b0;
            w_head_dy    = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state      <= ST_IDLE;
            r_lock_route <= 2'b00;
            r_lock_dx    <= 1'b0;
            r_lock_dy    <= 1'b0;
            r_out_valid  <= 1'b0;
            r_out_flit   <= '0;
            r_out_head   <= 1'b0;
            r_out_tail   <= 1'b0;
            r_out_route  <= 2'b00;
            r_out_dx     <= 1'b0;
            r_out_dy     <= 1'b0;
            r_pkt_cnt    <= '0;
        end else begin
            if (w_consume && r_out_tail) begin
                r_pkt_cnt <= r_pkt_cnt + 1'b1;
            end

            if (w_accept) begin
                r_out_valid <= 1'b1;
                r_out_flit  <= bus.in_flit_i;
                r_out_head  <= bus.in_head_i;
                r_out_tail  <= bus.in_tail_i;
                if (bus.in_head_i) begin
                    // Any head (even mid-packet) starts a fresh packet.
                    r_lock_route <= w_head_route;
                    r_lock_dx    <= w_head_dx;
                    r_lock_dy    <= w_head_dy;
                    r_out_route  <= w_head_route;
                    r_out_dx     <= w_head_dx;
                    r_out_dy     <= w_head_dy;
                    r_state      <= bus.in_tail_i ? ST_IDLE : ST_BODY;
                end else begin
                    r_out_route  <= r_lock_route;
                    r_out_dx     <= r_lock_dx;
                    r_out_dy     <= r_lock_dy;
                    if (bus.in_tail_i) begin
                        r_state <= ST_IDLE;
                    end
                end
            end else if (w_consume) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign bus.in_ready_o  = w_in_ready;
    assign bus.out_valid_o = r_out_valid;
    assign bus.out_flit_o  = r_out_flit;
    assign bus.out_head_o  = r_out_head;
    assign bus.out_tail_o  = r_out_tail;
    assign bus.route_o     = r_out_route;
    assign bus.dir_x_o     = r_out_dx;
    assign bus.dir_y_o     = r_out_dy;
    assign bus.pkt_cnt_o   = r_pkt_cnt;
endmodule
`default_nettype wire

// File: tb/tb_router_route_lock.sv
`default_nettype none
// ============================================================================
// Module : tb_router_route_lock
// Brief  : Self-checking bench; dut_a is a 4x4 mesh, dut_b a 4x5 mesh with a
//          2-bit packet counter. Both routers sit at (2,2).
// Rev    : 1.0  initial release
// ============================================================================
module tb_router_route_lock;
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    router_route_lock_if #(.FLIT_W(32), .CNT_W(16)) a ();
    router_route_lock_if #(.FLIT_W(32), .CNT_W(2))  b ();

    router_route_lock #(.MAXX(4), .MAXY(4), .SELFX(2), .SELFY(2), .FLIT_W(32), .CNT_W(16))
        dut_a (.clk_i(clk), .rst_ni(rst_n), .bus(a.slave));
    router_route_lock #(.MAXX(4), .MAXY(5), .SELFX(2), .SELFY(2), .FLIT_W(32), .CNT_W(2))
        dut_b (.clk_i(clk), .rst_ni(rst_n), .bus(b.slave));

    int errors = 0;
    int checks = 0;

    // Reference model per DUT: expected output register and the packet's route.
    int          maxy[2]   = '{4, 5};
    int          cntmod[2] = '{65536, 4};
    bit          m_valid[2];
    logic [37:0] m_out[2];
    bit          m_tail[2];
    logic [3:0]  m_lock[2];
    bit          m_open[2];
    int          m_cnt[2];
    bit          m_err[2];

    task automatic model_reset();
        for (int s = 0; s < 2; s++) begin
            m_valid[s] = 0; m_out[s] = '0; m_tail[s] = 0; m_lock[s] = '0;
            m_open[s] = 0; m_cnt[s] = 0; m_err[s] = 0;
        end
    endtask

    function automatic logic [31:0] mkflit(input int sel, input int dx, input int dy);
        logic [31:0] f;
        f = $urandom();
        f[1:0] = 2'(dx);
        if (sel == 0) f[3:2] = 2'(dy);
        else          f[4:2] = 3'(dy);
        return f;
    endfunction

    // {route[1:0], dir_x, dir_y} from plain coordinate arithmetic.
    function automatic logic [3:0] classify(input int sel, input logic [31:0] f, output bit bad);
        int dx, dy;
        logic [1:0] r;
        dx  = int'(f[1:0]);
        dy  = (sel == 0) ? int'(f[3:2]) : int'(f[4:2]);
        bad = (dx >= 4) || (dy >= maxy[sel]);
        if (dx == 2 && dy == 2) r = 2'b00;
        else if (dx == 2)       r = 2'b01;
        else if (dy == 2)       r = 2'b10;
        else                    r = 2'b11;
`ifdef ROUTE_ERRCHK_EN
        if (bad) return 4'b0000;
`endif
        return {r, dx > 2, dy > 2};
    endfunction

    // Drive one cycle into DUT sel, advance the model and score the result.
    task automatic step(input int sel, input logic v, input logic [31:0] f, input logic h,
                        input logic t, input logic rdy, output bit acc);
        logic        rdy_o, ov, oe, exp_rdy;
        logic [37:0] ob;
        int          oc;
        logic [3:0]  rt;
        bit          bad;
        a.in_valid_i = (sel == 0) ? v : 1'b0;  a.in_flit_i = f; a.in_head_i = h; a.in_tail_i = t;
        a.out_ready_i = (sel == 0) ? rdy : 1'b0;
        b.in_valid_i = (sel == 1) ? v : 1'b0;  b.in_flit_i = f; b.in_head_i = h; b.in_tail_i = t;
        b.out_ready_i = (sel == 1) ? rdy : 1'b0;
        #1;
        rdy_o   = (sel == 0) ? a.in_ready_o : b.in_ready_o;
        exp_rdy = !m_valid[sel] || rdy;
        checks++;
        if (rdy_o !== exp_rdy) begin
            errors++;
            $display("FAIL in_ready dut=%0d got=%b want=%b t=%0t", sel, rdy_o, exp_rdy, $time);
        end
        acc = v && exp_rdy;
        @(posedge clk);
        if (m_valid[sel] && rdy && m_tail[sel]) m_cnt[sel] = (m_cnt[sel] + 1) % cntmod[sel];
        if (acc) begin
            if (h) begin
                rt = classify(sel, f, bad);
`ifdef ROUTE_ERRCHK_EN
                if (bad || m_open[sel]) m_err[sel] = 1;
`endif
                m_lock[sel] = rt;
                m_open[sel] = !t;
            end else begin
`ifdef ROUTE_ERRCHK_EN
                if (!m_open[sel]) m_err[sel] = 1;
`endif
                m_open[sel] = m_open[sel] && !t;
            end
            m_out[sel]   = {f, h, t, m_lock[sel]};
            m_tail[sel]  = t;
            m_valid[sel] = 1;
        end else if (m_valid[sel] && rdy) begin
            m_valid[sel] = 0;
        end
        #1;
        if (sel == 0) begin
            ov = a.out_valid_o; oe = a.err_o; oc = int'(a.pkt_cnt_o);
            ob = {a.out_flit_o, a.out_head_o, a.out_tail_o, a.route_o, a.dir_x_o, a.dir_y_o};
        end else begin
            ov = b.out_valid_o; oe = b.err_o; oc = int'(b.pkt_cnt_o);
            ob = {b.out_flit_o, b.out_head_o, b.out_tail_o, b.route_o, b.dir_x_o, b.dir_y_o};
        end
        checks++;
        if (ov !== m_valid[sel]) begin
            errors++;
            $display("FAIL out_valid dut=%0d got=%b want=%b t=%0t", sel, ov, m_valid[sel], $time);
        end
        if (m_valid[sel]) begin
            checks++;
            if (ob !== m_out[sel]) begin
                errors++;
                $display("FAIL out_bundle dut=%0d got=%h want=%h t=%0t", sel, ob, m_out[sel], $time);
            end
        end
        checks++;
        if (oc !== m_cnt[sel]) begin
            errors++;
            $display("FAIL pkt_cnt dut=%0d got=%0d want=%0d t=%0t", sel, oc, m_cnt[sel], $time);
        end
        checks++;
        if (oe !== m_err[sel]) begin
            errors++;
            $display("FAIL err dut=%0d got=%b want=%b t=%0t", sel, oe, m_err[sel], $time);
        end
    endtask

    task automatic test_reset();
        a.in_valid_i = 0; a.in_flit_i = '0; a.in_head_i = 0; a.in_tail_i = 0; a.out_ready_i = 0;
        b.in_valid_i = 0; b.in_flit_i = '0; b.in_head_i = 0; b.in_tail_i = 0; b.out_ready_i = 0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({a.out_valid_o, a.out_flit_o, a.out_head_o, a.out_tail_o, a.route_o, a.dir_x_o,
             a.dir_y_o, a.pkt_cnt_o, a.err_o} !== '0) begin
            errors++;
            $display("FAIL reset_a got=%b/%h cnt=%0d want=all zero", a.out_valid_o, a.out_flit_o, a.pkt_cnt_o);
        end
        checks++;
        if ({b.out_valid_o, b.out_flit_o, b.route_o, b.pkt_cnt_o, b.err_o} !== '0) begin
            errors++;
            $display("FAIL reset_b got=%b/%h cnt=%0d want=all zero", b.out_valid_o, b.out_flit_o, b.pkt_cnt_o);
        end
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_route_classes();
        int         dst[4][2] = '{'{2, 2}, '{2, 0}, '{3, 2}, '{0, 3}};
        logic [3:0] tab[4]    = '{4'b0000, 4'b0100, 4'b1010, 4'b1101};
        bit acc;
        for (int i = 0; i < 4; i++) begin
            step(0, 1, mkflit(0, dst[i][0], dst[i][1]), 1, 1, 1, acc);
            checks++;
            if ({a.route_o, a.dir_x_o, a.dir_y_o} !== tab[i]) begin
                errors++;
                $display("FAIL route_class%0d got=%b want=%b", i, {a.route_o, a.dir_x_o, a.dir_y_o}, tab[i]);
            end
        end
        step(0, 0, '0, 0, 0, 1, acc);
        checks++;
        if (a.pkt_cnt_o !== 16'd4) begin
            errors++;
            $display("FAIL route_class_cnt got=%0d want=4", a.pkt_cnt_o);
        end
    endtask

    task automatic test_long_packet();
        bit acc;
        for (int i = 0; i < 4; i++) begin
            step(0, 1, (i == 0) ? mkflit(0, 1, 1) : $urandom(), i == 0, i == 3, 1, acc);
            checks++;
            if ({a.route_o, a.dir_x_o, a.dir_y_o} !== 4'b1100) begin
                errors++;
                $display("FAIL long_pkt flit%0d got=%b want=1100", i, {a.route_o, a.dir_x_o, a.dir_y_o});
            end
        end
        step(0, 0, '0, 0, 0, 1, acc);
        checks++;
        if (a.pkt_cnt_o !== 16'd5) begin
            errors++;
            $display("FAIL long_pkt_cnt got=%0d want=5", a.pkt_cnt_o);
        end
    endtask

    task automatic test_stall_stream();
        bit acc;
        logic [31:0] held;
        step(0, 1, mkflit(0, 3, 3), 1, 0, 1, acc);
        step(0, 1, $urandom(), 0, 0, 1, acc);
        held = $urandom();
        repeat (3) step(0, 1, held, 0, 0, 0, acc);
        step(0, 1, held, 0, 0, 1, acc);
        for (int i = 0; i < 8; i++) begin
            step(0, 1, $urandom(), 0, i == 7, 1, acc);
            checks++;
            if (!acc) begin
                errors++;
                $display("FAIL stream_rate flit%0d got=stalled want=accepted", i);
            end
        end
        step(0, 0, '0, 0, 0, 1, acc);
    endtask

    task automatic test_random();
        int left = 0;
        bit pend = 0;
        bit acc;
        logic [31:0] f = '0;
        logic h = 0, t = 0;
        for (int i = 0; i < 400; i++) begin
            if (!pend) begin
                if (left == 0) begin
                    left = $urandom_range(1, 4);
                    h = 1;
                    f = mkflit(0, $urandom_range(0, 3), $urandom_range(0, 3));
                end else begin
                    h = 0;
                    f = $urandom();
                end
                t = (left == 1);
                pend = 1;
            end
            step(0, $urandom_range(0, 3) != 0, f, h, t, $urandom_range(0, 3) != 0, acc);
            if (acc) begin
                pend = 0;
                left--;
            end
        end
        while (pend) begin
            step(0, 1, f, h, t, 1, acc);
            if (acc) begin
                pend = 0;
                left--;
                if (left > 0) begin
                    f = $urandom(); h = 0; t = (left == 1); pend = 1;
                end
            end
        end
        step(0, 0, '0, 0, 0, 1, acc);
    endtask

    task automatic test_reset_mid();
        bit acc;
        step(0, 1, mkflit(0, 0, 0), 1, 0, 1, acc);
        step(0, 1, $urandom(), 0, 0, 0, acc);
        a.in_valid_i = 0;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({a.out_valid_o, a.out_flit_o, a.out_head_o, a.out_tail_o, a.route_o, a.dir_x_o,
             a.dir_y_o, a.pkt_cnt_o, a.err_o} !== '0) begin
            errors++;
            $display("FAIL reset_mid got=%b/%h route=%b cnt=%0d want=all zero",
                     a.out_valid_o, a.out_flit_o, a.route_o, a.pkt_cnt_o);
        end
        model_reset();
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk);
        #1;
        step(0, 1, mkflit(0, 0, 0), 0, 0, 1, acc);
        checks++;
        if ({a.route_o, a.dir_x_o, a.dir_y_o} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_mid_body got=%b want=0000", {a.route_o, a.dir_x_o, a.dir_y_o});
        end
        step(0, 1, mkflit(0, 1, 3), 1, 1, 1, acc);
        step(0, 0, '0, 0, 0, 1, acc);
    endtask

    task automatic test_cnt_wrap();
        int seq[5] = '{1, 2, 3, 0, 1};
        bit acc;
        for (int k = 0; k < 6; k++) begin
            step(1, k < 5, mkflit(1, $urandom_range(0, 3), $urandom_range(0, 4)), 1, 1, 1, acc);
            if (k >= 1) begin
                checks++;
                if (int'(b.pkt_cnt_o) !== seq[k-1]) begin
                    errors++;
                    $display("FAIL cnt_wrap step%0d got=%0d want=%0d", k, b.pkt_cnt_o, seq[k-1]);
                end
            end
        end
    endtask

    task automatic test_errchk();
        bit acc;
        logic       want_err;
        logic [3:0] want_rt;
`ifdef ROUTE_ERRCHK_EN
        want_err = 1'b1; want_rt = 4'b0000;
`else
        want_err = 1'b0; want_rt = 4'b1111;
`endif
        for (int i = 0; i < 3; i++) begin
            step(1, 1, (i == 0) ? mkflit(1, 3, 5) : $urandom(), i == 0, i == 2, 1, acc);
            checks++;
            if ({b.route_o, b.dir_x_o, b.dir_y_o} !== want_rt) begin
                errors++;
                $display("FAIL errchk_route flit%0d got=%b want=%b", i, {b.route_o, b.dir_x_o, b.dir_y_o}, want_rt);
            end
        end
        step(1, 0, '0, 0, 0, 1, acc);
        checks++;
        if (b.err_o !== want_err) begin
            errors++;
            $display("FAIL errchk_flag got=%b want=%b", b.err_o, want_err);
        end
    endtask

    initial begin
        test_reset();
        test_route_classes();
        test_long_packet();
        test_stall_stream();
        test_random();
        test_reset_mid();
        test_cnt_wrap();
        test_errchk();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
`default_nettype wire
